// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad entry block.
// Holds the FSM state encoding, the per-scan result format and the
// row/column to hex code table.
package keypad_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_e;

  // Result of one full scan: valid=0 means no key, or more than one key.
  typedef struct packed {
    logic       valid;
    logic [1:0] r;
    logic [1:0] c;
  } scan_res_t;

  localparam scan_res_t RES_NONE = scan_res_t'(5'b00000);

  // Keypad legend, row r / column c:
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  function automatic logic [3:0] key_hex(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner and debouncer for a 4x4 active-low matrix keypad.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   row_i        - keypad rows, active-low, already synchronised
//   col_o        - column drive, active-low, one bit low at a time
//   scan_end_o   - high on the last cycle of a full 4-column scan
//   result_o     - result of the scan finishing this cycle
//   stable_o     - result_o has now been seen DEBOUNCE_SCANS scans in a row
//                  (qualify with scan_end_o)
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 18,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      row_i,
  output logic [3:0]      col_o,
  output logic            scan_end_o,
  output scan_res_t       result_o,
  output logic            stable_o
);

  localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_SCANS);

  logic [SCAN_DIV_W-1:0] div_q, div_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            low_cnt_q, low_cnt_d;   // low bits seen so far, saturates at 2
  logic [3:0]            pos_q, pos_d;           // {r,c} of the first low bit seen
  scan_res_t             prev_q, prev_d;
  logic [3:0]            cnt_q, cnt_d;

  logic       sample;
  logic [3:0] row_low;
  logic [2:0] n_low;
  logic [1:0] low_row;
  logic [2:0] tot;
  logic [1:0] acc_cnt;
  logic [3:0] acc_pos;
  logic [3:0] cnt_nxt;
  scan_res_t  result;

  assign col_o = ~(4'b0001 << idx_q);

  always_comb begin
    sample  = &div_q;
    row_low = ~row_i;
    n_low   = {2'b00, row_low[0]} + {2'b00, row_low[1]} +
              {2'b00, row_low[2]} + {2'b00, row_low[3]};
    low_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_low[r]) low_row = 2'(r);
    end

    tot     = {1'b0, low_cnt_q} + n_low;
    acc_cnt = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    // Position only matters when exactly one low bit exists over the whole scan.
    acc_pos = (low_cnt_q == 2'd0 && n_low == 3'd1) ? {low_row, idx_q} : pos_q;

    result = RES_NONE;
    if (acc_cnt == 2'd1) result = '{valid: 1'b1, r: acc_pos[3:2], c: acc_pos[1:0]};

    if (result == prev_q) cnt_nxt = (cnt_q == DB_CNT) ? cnt_q : cnt_q + 4'd1;
    else                  cnt_nxt = 4'd1;

    div_d     = div_q + 1'b1;
    idx_d     = idx_q;
    low_cnt_d = low_cnt_q;
    pos_d     = pos_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    if (sample) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        low_cnt_d = 2'd0;
        pos_d     = 4'd0;
        prev_d    = result;
        cnt_d     = cnt_nxt;
      end else begin
        low_cnt_d = acc_cnt;
        pos_d     = acc_pos;
      end
    end
  end

  assign scan_end_o = sample && (idx_q == 2'd3);
  assign result_o   = result;
  assign stable_o   = (cnt_nxt == DB_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      idx_q     <= 2'd0;
      low_cnt_q <= 2'd0;
      pos_q     <= 4'd0;
      prev_q    <= RES_NONE;
      cnt_q     <= 4'd0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      low_cnt_q <= low_cnt_d;
      pos_q     <= pos_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 keypad hex entry: scans and debounces the keypad, accepts keypresses
// and shifts accepted hex digits into a 16-bit value (newest in [3:0]).
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   row         - keypad rows, active-low
//   col         - keypad column drive, active-low
//   clear       - synchronous clear of value (wins over a coinciding accept)
//   value       - entered digits
//   key_code    - hex code of the most recently accepted key
//   key_valid   - one-cycle accept pulse
//   key_held    - accepted key still debounced-pressed
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no key accepted, waiting for a stable keypress
// ST_PRESSED | key accepted, waiting for stable release
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 18,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  logic      scan_end;
  logic      stable;
  scan_res_t res;

  keypad_scan #(
    .SCAN_DIV_W    (SCAN_DIV_W),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_i     (row),
    .col_o     (col),
    .scan_end_o(scan_end),
    .result_o  (res),
    .stable_o  (stable)
  );

  state_e      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic [3:0]  hex;
  logic        accept;

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    accept  = 1'b0;
    hex     = key_hex(res.r, res.c);

    if (scan_end && stable) begin
      if (res.valid) begin
        // A different stable key while pressed counts as a fresh press.
        if (state_q == ST_IDLE || hex != code_q) accept = 1'b1;
      end else if (state_q == ST_PRESSED) begin
        state_d = ST_IDLE;
        held_d  = 1'b0;
      end
    end

    if (accept) begin
      state_d = ST_PRESSED;
      code_d  = hex;
      held_d  = 1'b1;
      valid_d = !clear;
      value_d = {value_q[11:0], hex};
    end

    if (clear) value_d = 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      value_q <= 16'h0000;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign value     = value_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
